actmem_read_decoder: RTL

// - Downstream consumer of one activation-memory bank (sram_actmem-style, 1-cycle read latency, no stall).
// - Takes a burst command (start address, word count) and issues back-to-back bank reads.
// - Decodes each packed word (5 trits per byte) into 2-bit trits and streams them out on a valid/ready port.
// - Credit-limited 2-entry buffer: bank reads never overrun a stalled consumer.

---
 rtl/actmem_read_pkg.sv | 39 +++
 rtl/actmem_read_decoder_ternary_byte_decoder.sv | 36 +++
 rtl/actmem_read_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/actmem_read_pkg.sv
// ------------------------------------------------------------------
// actmem_read_pkg : shared types and helpers for actmem_read_decoder  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package actmem_read_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  localparam int         C_TRITS_PER_BYTE = 5;
  localparam logic [7:0] C_MAX_VALID_BYTE = 8'd242;

  function automatic int eff_trits(input int n_i, input int stagger);
    return n_i / stagger;
  endfunction

  function automatic int phys_trits(input int eff);
    return ((eff + C_TRITS_PER_BYTE - 1) / C_TRITS_PER_BYTE) * C_TRITS_PER_BYTE;
  endfunction

  function automatic logic [1:0] digit_to_trit(input logic [1:0] digit);
    case (digit)
      2'd0:    return TRIT_ZERO;
      2'd1:    return TRIT_POS;
      default: return TRIT_NEG;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/actmem_read_decoder_ternary_byte_decoder.sv
// ------------------------------------------------------------------
// ternary_byte_decoder : one packed byte -> up to five 2-bit trits  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ternary_byte_decoder
  import actmem_read_pkg::*;
#(
  parameter int N_KEEP = 5
) (
  input  logic [7:0]          i_byte,
  output logic [2*N_KEEP-1:0] o_trits,
  output logic                o_invalid
);

  logic [7:0] w_rem;
  logic [1:0] w_digit;

  // Only the trits the consumer keeps are extracted; an invalid byte yields zeros.
  always_comb begin
    o_trits   = '0;
    w_rem     = i_byte;
    w_digit   = '0;
    o_invalid = (i_byte > C_MAX_VALID_BYTE);
    for (int k = 0; k < N_KEEP; k++) begin
      w_digit = 2'(w_rem % 8'd3);
      w_rem   = w_rem / 8'd3;
      if (!o_invalid) begin
        o_trits[2*k +: 2] = digit_to_trit(w_digit);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/actmem_read_decoder.sv
// ------------------------------------------------------------------
// actmem_read_decoder : burst bank reader with credit-limited ternary unpacker  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module actmem_read_decoder
  import actmem_read_pkg::*;
#(
  parameter int N_I            = 12,
  parameter int WEIGHT_STAGGER = 1,
  parameter int NUM_WORDS      = 10,
  parameter int EFF_TRITS      = eff_trits(N_I, WEIGHT_STAGGER),
  parameter int PHYS_TRITS     = phys_trits(EFF_TRITS),
  parameter int DATA_WIDTH     = PHYS_TRITS / C_TRITS_PER_BYTE * 8,
  parameter int AW             = $clog2(NUM_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AW-1:0]          cmd_addr_i,
  input  logic [AW:0]            cmd_len_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_be_o,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EFF_TRITS*2-1:0] out_trits_o,
  output logic                   out_last_o,
  output logic                   err_o
);

  localparam int            NB          = PHYS_TRITS / C_TRITS_PER_BYTE;
  localparam logic [AW-1:0] C_LAST_ADDR = AW'(NUM_WORDS - 1);
  localparam logic [AW:0]   C_ONE_LEN   = (AW+1)'(1);

  fsm_e                  r_state;
  logic [AW-1:0]         r_addr;
  logic [AW:0]           r_rem;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic                  r_err;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_req;
  logic [DATA_WIDTH-1:0] w_head;
  logic [NB-1:0]         w_invalid;

  assign out_valid_o = (r_cnt != 2'd0);
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_push      = r_inflight;

  // Credit: words buffered plus words in flight, minus the one leaving now, must stay below 2.
  assign w_req = (r_state == RUN) &&
                 (({1'b0, r_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign cmd_ready_o = (r_state == IDLE);
  assign mem_req_o   = w_req;
  assign mem_addr_o  = r_addr;
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = '1;
  assign w_head      = r_buf_data[r_rptr];
  assign out_last_o  = out_valid_o && r_buf_last[r_rptr];
  assign err_o       = r_err;

  for (genvar b = 0; b < NB; b++) begin : g_dec
    localparam int KEEP = ((EFF_TRITS - C_TRITS_PER_BYTE*b) >= C_TRITS_PER_BYTE)
                          ? C_TRITS_PER_BYTE : (EFF_TRITS - C_TRITS_PER_BYTE*b);
    ternary_byte_decoder #(
      .N_KEEP (KEEP)
    ) u_dec (
      .i_byte    (w_head[8*b +: 8]),
      .o_trits   (out_trits_o[2*C_TRITS_PER_BYTE*b +: 2*KEEP]),
      .o_invalid (w_invalid[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_buf_last      <= '0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_cnt           <= '0;
      r_err           <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid_i && (cmd_len_i != '0)) begin
            r_addr  <= cmd_addr_i;
            r_rem   <= cmd_len_i;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_req) begin
            r_addr <= (r_addr == C_LAST_ADDR) ? '0 : r_addr + AW'(1);
            r_rem  <= r_rem - C_ONE_LEN;
            if (r_rem == C_ONE_LEN) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && out_last_o) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Bank data returns one cycle after the request; the last flag rides alongside.
      r_inflight      <= w_req;
      r_inflight_last <= w_req && (r_rem == C_ONE_LEN);

      if (w_push) begin
        r_buf_data[r_wptr] <= mem_rdata_i;
        r_buf_last[r_wptr] <= r_inflight_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_err  <= r_err | (|w_invalid);
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire
